// File: rtl/layer_sequencer_ctrl.sv
// Multi-layer sequencer for the neuron-array datapath.
// For each layer it loads the kernel registers, fills the input buffer, then
// runs the PE accumulate and writes one result for every output position.
// Memory beats advance only when mem_ready accepts them. All outputs are
// decoded from the registered state and counters.
module layer_sequencer_ctrl #(
  parameter int NEURONS    = 4,
  parameter int KERNEL_LEN = 4,
  parameter int BUF_LEN    = 64,
  parameter int PE_CYCLES  = 16,
  parameter int MAX_LAYERS = 4,
  parameter int ADDR_W     = 8,
  parameter int IDX_W      = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [2:0]                   num_layers,
  input  logic [MAX_LAYERS*ADDR_W-1:0] cfg_wbase,
  input  logic [MAX_LAYERS*ADDR_W-1:0] cfg_ibase,
  input  logic [MAX_LAYERS*ADDR_W-1:0] cfg_obase,
  input  logic [MAX_LAYERS*IDX_W-1:0]  cfg_rows,
  input  logic [MAX_LAYERS*IDX_W-1:0]  cfg_cols,
  input  logic                         mem_ready,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_rd,
  output logic                         mem_wr,
  output logic [NEURONS-1:0]           load_kernel,
  output logic                         load_buffer,
  output logic                         sum_reset,
  output logic                         sum_en,
  output logic [1:0]                   layer_idx,
  output logic [IDX_W-1:0]             row_i,
  output logic [IDX_W-1:0]             col_j,
  output logic                         busy,
  output logic                         done
);

  // One shared width for every beat/cycle counter; wide enough for the largest.
  localparam int CNT_W = $clog2(BUF_LEN + PE_CYCLES + NEURONS + KERNEL_LEN + 1);
  // Address sums are formed wider than the bus and then wrapped.
  localparam int SUM_W = ADDR_W + IDX_W;

  localparam logic [CNT_W-1:0] WORD_LAST   = CNT_W'(KERNEL_LEN - 1);
  localparam logic [CNT_W-1:0] NEURON_LAST = CNT_W'(NEURONS - 1);
  localparam logic [CNT_W-1:0] BUF_LAST    = CNT_W'(BUF_LEN - 1);
  localparam logic [CNT_W-1:0] PE_LAST     = CNT_W'(PE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KERNEL,
    LOAD_BUFFER,
    PE,
    WRITE,
    NEXT_IDX,
    NEXT_LAYER,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] neuron_cnt;
  logic [CNT_W-1:0] buf_cnt;
  logic [CNT_W-1:0] pe_cnt;

  logic [ADDR_W-1:0] wbase_cur;
  logic [ADDR_W-1:0] ibase_cur;
  logic [ADDR_W-1:0] obase_cur;
  logic [IDX_W-1:0]  rows_cur;
  logic [IDX_W-1:0]  cols_cur;
  logic [2:0]        last_layer;
  logic              col_more;
  logic              row_more;
  logic              layer_last;

  // Select the live configuration of the current layer and the clamped layer count.
  always_comb begin
    wbase_cur  = cfg_wbase[layer_idx*ADDR_W +: ADDR_W];
    ibase_cur  = cfg_ibase[layer_idx*ADDR_W +: ADDR_W];
    obase_cur  = cfg_obase[layer_idx*ADDR_W +: ADDR_W];
    rows_cur   = cfg_rows[layer_idx*IDX_W +: IDX_W];
    cols_cur   = cfg_cols[layer_idx*IDX_W +: IDX_W];
    last_layer = ((num_layers > 3'(MAX_LAYERS)) ? 3'(MAX_LAYERS) : num_layers) - 3'd1;
    col_more   = col_j < (cols_cur - IDX_W'(1));
    row_more   = row_i < (rows_cur - IDX_W'(1));
    layer_last = ({1'b0, layer_idx} == last_layer);
  end

  // State register; an asynchronous reset aborts any run in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decision; memory phases only move on an accepted beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (start) state_nxt = (num_layers == 3'd0) ? DONE : LOAD_KERNEL;
      LOAD_KERNEL: if (mem_ready && word_cnt == WORD_LAST && neuron_cnt == NEURON_LAST)
                     state_nxt = LOAD_BUFFER;
      LOAD_BUFFER: if (mem_ready && buf_cnt == BUF_LAST) state_nxt = PE;
      PE:          if (pe_cnt == PE_LAST) state_nxt = WRITE;
      WRITE:       if (mem_ready) state_nxt = NEXT_IDX;
      NEXT_IDX:    state_nxt = (col_more || row_more) ? PE : NEXT_LAYER;
      NEXT_LAYER:  state_nxt = layer_last ? DONE : LOAD_KERNEL;
      DONE:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Beat counters and output indices; every counter freezes while a beat stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_cnt   <= '0;
      neuron_cnt <= '0;
      buf_cnt    <= '0;
      pe_cnt     <= '0;
      layer_idx  <= '0;
      row_i      <= '0;
      col_j      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            word_cnt   <= '0;
            neuron_cnt <= '0;
            buf_cnt    <= '0;
            pe_cnt     <= '0;
            layer_idx  <= '0;
            row_i      <= '0;
            col_j      <= '0;
          end
        end
        LOAD_KERNEL: begin
          if (mem_ready) begin
            if (word_cnt == WORD_LAST) begin
              word_cnt   <= '0;
              neuron_cnt <= (neuron_cnt == NEURON_LAST) ? '0 : neuron_cnt + CNT_W'(1);
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end
        LOAD_BUFFER: begin
          if (mem_ready) buf_cnt <= (buf_cnt == BUF_LAST) ? '0 : buf_cnt + CNT_W'(1);
        end
        PE: begin
          pe_cnt <= (pe_cnt == PE_LAST) ? '0 : pe_cnt + CNT_W'(1);
        end
        NEXT_IDX: begin
          if (col_more) begin
            col_j <= col_j + IDX_W'(1);
          end else begin
            col_j <= '0;
            if (row_more) row_i <= row_i + IDX_W'(1);
          end
        end
        NEXT_LAYER: begin
          row_i <= '0;
          col_j <= '0;
          if (!layer_last) layer_idx <= layer_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Moore output decode from state and counters; idle drives everything low.
  always_comb begin
    mem_addr    = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    load_kernel = '0;
    load_buffer = 1'b0;
    sum_reset   = 1'b0;
    sum_en      = 1'b0;
    busy        = (state != IDLE);
    done        = 1'b0;
    case (state)
      LOAD_KERNEL: begin
        mem_addr    = ADDR_W'(SUM_W'(wbase_cur) + SUM_W'(neuron_cnt) * SUM_W'(KERNEL_LEN)
                              + SUM_W'(word_cnt));
        mem_rd      = 1'b1;
        load_kernel = NEURONS'(1) << neuron_cnt;
      end
      LOAD_BUFFER: begin
        mem_addr    = ADDR_W'(SUM_W'(ibase_cur) + SUM_W'(buf_cnt));
        mem_rd      = 1'b1;
        load_buffer = 1'b1;
        sum_reset   = 1'b1;
      end
      PE: sum_en = 1'b1;
      WRITE: begin
        mem_addr = ADDR_W'(SUM_W'(obase_cur) + SUM_W'(row_i) * SUM_W'(cols_cur)
                           + SUM_W'(col_j));
        mem_wr   = 1'b1;
      end
      NEXT_IDX: sum_reset = 1'b1;
      DONE:     done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_layer_sequencer_ctrl.sv
// Randomised bench for layer_sequencer_ctrl: a transaction-level model lists
// every expected memory beat and the run latency for each configuration.
module tb_layer_sequencer_ctrl;

  localparam int NEURONS    = 4;
  localparam int KERNEL_LEN = 4;
  localparam int BUF_LEN    = 64;
  localparam int PE_CYCLES  = 16;
  localparam int MAX_LAYERS = 4;
  localparam int ADDR_W     = 8;
  localparam int IDX_W      = 4;

  logic                         clock = 1'b0;
  logic                         reset;
  logic                         start;
  logic [2:0]                   num_layers;
  logic [MAX_LAYERS*ADDR_W-1:0] cfg_wbase, cfg_ibase, cfg_obase;
  logic [MAX_LAYERS*IDX_W-1:0]  cfg_rows, cfg_cols;
  logic                         mem_ready;
  logic [ADDR_W-1:0]            mem_addr;
  logic                         mem_rd, mem_wr;
  logic [NEURONS-1:0]           load_kernel;
  logic                         load_buffer, sum_reset, sum_en;
  logic [1:0]                   layer_idx;
  logic [IDX_W-1:0]             row_i, col_j;
  logic                         busy, done;

  layer_sequencer_ctrl #(
    .NEURONS(NEURONS), .KERNEL_LEN(KERNEL_LEN), .BUF_LEN(BUF_LEN), .PE_CYCLES(PE_CYCLES),
    .MAX_LAYERS(MAX_LAYERS), .ADDR_W(ADDR_W), .IDX_W(IDX_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .num_layers(num_layers),
    .cfg_wbase(cfg_wbase), .cfg_ibase(cfg_ibase), .cfg_obase(cfg_obase),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .load_kernel(load_kernel),
    .load_buffer(load_buffer), .sum_reset(sum_reset), .sum_en(sum_en),
    .layer_idx(layer_idx), .row_i(row_i), .col_j(col_j), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit wr;
    int addr;
    int lk;
    bit lb;
    int layer;
    int row;
    int col;
  } beat_t;

  beat_t exp_q[$];
  int wb[MAX_LAYERS], ib[MAX_LAYERS], ob[MAX_LAYERS], rr[MAX_LAYERS], cc[MAX_LAYERS];

  // Expected beat list and mem_ready-high latency, straight from the layer rules.
  task automatic build_model(input int nl_req, output int lat);
    int nl;
    nl = (nl_req > MAX_LAYERS) ? MAX_LAYERS : nl_req;
    exp_q.delete();
    lat = 1;
    for (int l = 0; l < nl; l++) begin
      for (int n = 0; n < NEURONS; n++)
        for (int k = 0; k < KERNEL_LEN; k++)
          exp_q.push_back(beat_t'{1'b0, (wb[l] + n*KERNEL_LEN + k) % 256, 1 << n, 1'b0, l, 0, 0});
      for (int b = 0; b < BUF_LEN; b++)
        exp_q.push_back(beat_t'{1'b0, (ib[l] + b) % 256, 0, 1'b1, l, 0, 0});
      for (int r = 0; r < rr[l]; r++)
        for (int c = 0; c < cc[l]; c++)
          exp_q.push_back(beat_t'{1'b1, (ob[l] + r*cc[l] + c) % 256, 0, 1'b0, l, r, c});
      lat += NEURONS*KERNEL_LEN + BUF_LEN + rr[l]*cc[l]*(PE_CYCLES + 2) + 1;
    end
  endtask

  task automatic pack_cfg();
    for (int l = 0; l < MAX_LAYERS; l++) begin
      cfg_wbase[l*ADDR_W +: ADDR_W] = ADDR_W'(wb[l]);
      cfg_ibase[l*ADDR_W +: ADDR_W] = ADDR_W'(ib[l]);
      cfg_obase[l*ADDR_W +: ADDR_W] = ADDR_W'(ob[l]);
      cfg_rows[l*IDX_W +: IDX_W]    = IDX_W'(rr[l]);
      cfg_cols[l*IDX_W +: IDX_W]    = IDX_W'(cc[l]);
    end
  endtask

  function automatic logic [63:0] out_snap();
    return {35'd0, mem_addr, mem_rd, mem_wr, load_kernel, load_buffer, sum_reset, sum_en,
            layer_idx, row_i, col_j, busy, done};
  endfunction

  // ready_mode: 0 always ready, 1 random stalls, 2 fixed 1,0,1,0 then 3 low on first write.
  task automatic run_job(input int nl_req, input int ready_mode, input bit poke_start);
    int lat_exp, cyc, stalls, wr_low, pe_run, budget;
    bit got_done, prev_stall;
    logic [63:0] snap, prev_snap;
    beat_t e;
    build_model(nl_req, lat_exp);
    pack_cfg();
    @(negedge clock);
    num_layers = 3'(nl_req);
    start      = 1'b1;
    mem_ready  = 1'b1;
    cyc = 0; stalls = 0; wr_low = 0; pe_run = 0; got_done = 0; prev_stall = 0;
    prev_snap = '0;
    budget = lat_exp + 2000;
    while (cyc < budget) begin
      @(negedge clock);
      cyc++;
      start = (poke_start && cyc == 40) ? 1'b1 : 1'b0;
      check_val("busy", busy, 1);
      if (done) begin
        got_done = 1;
        check_val("latency", cyc, lat_exp + stalls);
        break;
      end
      case (ready_mode)
        1:       mem_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (cyc <= 4)                   mem_ready = cyc[0];
          else if (mem_wr && wr_low < 3) begin mem_ready = 1'b0; wr_low++; end
          else                            mem_ready = 1'b1;
        end
        default: mem_ready = 1'b1;
      endcase
      snap = out_snap();
      if (prev_stall) check_val("stall_hold", snap, prev_snap);
      prev_stall = (mem_rd || mem_wr) && !mem_ready;
      prev_snap  = snap;
      if (prev_stall) stalls++;
      if (mem_rd) check_val("rd_sum_reset", sum_reset, load_buffer);
      if (sum_en) pe_run++;
      if ((mem_rd || mem_wr) && mem_ready) begin
        if (exp_q.size() == 0) begin
          check_val("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("beat_wr", mem_wr, e.wr);
          check_val("beat_addr", mem_addr, e.addr);
          check_val("load_kernel", load_kernel, e.lk);
          check_val("load_buffer", load_buffer, e.lb);
          check_val("beat_layer", layer_idx, e.layer);
          if (e.wr) begin
            check_val("write_row", row_i, e.row);
            check_val("write_col", col_j, e.col);
            check_val("pe_cycles", pe_run, PE_CYCLES);
            pe_run = 0;
          end
        end
      end
    end
    if (!got_done) check_val("done_timeout", 0, 1);
    check_val("beats_left", exp_q.size(), 0);
    if (ready_mode == 2) check_val("stall_count", stalls, 5);
    mem_ready = 1'b1;
    @(negedge clock);
    check_val("done_pulse", done, 0);
    check_val("idle_busy", busy, 0);
    check_val("idle_addr", mem_addr, 0);
  endtask

  // Reset during PE of layer 1 must clear everything at once and never give done.
  task automatic abort_job();
    int lat_exp, cyc;
    bit hit;
    build_model(2, lat_exp);
    pack_cfg();
    @(negedge clock);
    num_layers = 3'd2;
    start      = 1'b1;
    mem_ready  = 1'b1;
    cyc = 0; hit = 0;
    while (cyc < lat_exp + 100) begin
      @(negedge clock);
      start = 1'b0;
      cyc++;
      if (done) check_val("abort_early_done", done, 0);
      if (sum_en && layer_idx == 2'd1 && cyc % 7 == 3) begin hit = 1; break; end
    end
    check_val("abort_reached_pe_l1", hit, 1);
    #2 reset = 1'b1;
    #1 check_val("abort_outputs", out_snap(), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_val("abort_no_done", done, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_val("abort_idle", {busy, done}, 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; num_layers = '0;
    for (int l = 0; l < MAX_LAYERS; l++) begin
      wb[l] = 0; ib[l] = 0; ob[l] = 0; rr[l] = 1; cc[l] = 1;
    end
    pack_cfg();
    repeat (3) @(negedge clock);
    check_val("reset_outputs", out_snap(), 0);
    reset = 1'b0;
    @(negedge clock);
    check_val("post_reset_idle", out_snap(), 0);

    // One layer, 2x2: 154-cycle latency, writes at obase+0..3.
    wb[0] = 16; ib[0] = 100; ob[0] = 200; rr[0] = 2; cc[0] = 2;
    run_job(1, 0, 1'b0);

    // Two layers, second 3x1; a start pulse mid-run is ignored.
    wb[1] = 40; ib[1] = 120; ob[1] = 60; rr[1] = 3; cc[1] = 1;
    run_job(2, 0, 1'b1);

    // Fixed stall pattern adds exactly five cycles.
    run_job(1, 2, 1'b0);

    // Zero layers: done on the next cycle, no memory traffic.
    run_job(0, 0, 1'b0);

    // Output address wrap: 250..255, 0, 1, 2.
    wb[0] = 250; ib[0] = 230; ob[0] = 250; rr[0] = 3; cc[0] = 3;
    run_job(1, 0, 1'b0);

    // Randomised configurations, layer counts including clamped ones, random stalls.
    for (int t = 0; t < 6; t++) begin
      for (int l = 0; l < MAX_LAYERS; l++) begin
        wb[l] = $urandom_range(0, 255);
        ib[l] = $urandom_range(0, 255);
        ob[l] = $urandom_range(0, 255);
        rr[l] = $urandom_range(1, 3);
        cc[l] = $urandom_range(1, 3);
      end
      run_job((t == 0) ? 7 : $urandom_range(0, 5), 1, t[0]);
    end

    // Abort mid-run, then a fresh run from layer 0 with normal timing.
    wb[0] = 8; ib[0] = 30; ob[0] = 140; rr[0] = 1; cc[0] = 2;
    wb[1] = 90; ib[1] = 10; ob[1] = 180; rr[1] = 2; cc[1] = 1;
    abort_job();
    run_job(2, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/layer_sequencer_ctrl.md
Name: layer_sequencer_ctrl

Overview:
- Parametrised multi-layer controller for the neuron-array datapath.
- Per layer: loads kernels into NEURONS kernel registers, fills the input buffer, runs the PE accumulate for every output position (i,j), and writes each result to memory.
- Generalises the fixed two-layer controller: runtime layer count, per-layer base addresses and output dimensions, start/done handshake, and memory back-pressure via mem_ready.

Parameters:
NEURONS, 4, number of neurons / kernel registers
KERNEL_LEN, 4, words per kernel
BUF_LEN, 64, words loaded into the input buffer per layer
PE_CYCLES, 16, accumulate cycles per output position
MAX_LAYERS, 4, maximum layers per run
ADDR_W, 8, memory address width
IDX_W, 4, width of row/column indices

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin run; sampled only in IDLE
num_layers  in  3  layers to run, 0..MAX_LAYERS
cfg_wbase  in  MAX_LAYERS*ADDR_W  per-layer kernel base address; layer L in slice [L*ADDR_W +: ADDR_W]
cfg_ibase  in  MAX_LAYERS*ADDR_W  per-layer input base address
cfg_obase  in  MAX_LAYERS*ADDR_W  per-layer output base address
cfg_rows  in  MAX_LAYERS*IDX_W  per-layer output rows, R >= 1
cfg_cols  in  MAX_LAYERS*IDX_W  per-layer output columns, C >= 1
mem_ready  in  1  memory accepts the current mem_rd/mem_wr beat
mem_addr  out  ADDR_W  memory address; 0 when idle
mem_rd  out  1  read request
mem_wr  out  1  write request
load_kernel  out  NEURONS  one-hot kernel register load strobe
load_buffer  out  1  input buffer load strobe
sum_reset  out  1  clear accumulators
sum_en  out  1  accumulate enable
layer_idx  out  2  current layer
row_i  out  IDX_W  current output row
col_j  out  IDX_W  current output column
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async): state IDLE; all counters and indices 0; all outputs 0. A reset mid-run aborts immediately; no done pulse.
- Outputs are decoded from registered state and counters (Moore). Config ports are sampled live and must stay stable while busy.
- IDLE:
  - start=1 and num_layers>0: clear counters and go to LOAD_KERNEL.
  - start=1 and num_layers=0: go to DONE with no memory access.
  - start while busy is ignored.
  - num_layers>MAX_LAYERS is clamped to MAX_LAYERS.
- LOAD_KERNEL:
  - Neuron n, word k: mem_addr=wbase+n*KERNEL_LEN+k, mem_rd=1, load_kernel[n]=1.
  - Counters advance only when mem_ready=1.
  - After NEURONS*KERNEL_LEN accepted beats, go to LOAD_BUFFER.
- LOAD_BUFFER:
  - Word b: mem_addr=ibase+b, mem_rd=1, load_buffer=1, sum_reset=1.
  - Advances on mem_ready; after BUF_LEN beats, go to PE.
- PE: sum_en=1 for exactly PE_CYCLES cycles (no stall), then go to WRITE.
- WRITE:
  - mem_addr=obase+row_i*C+col_j, mem_wr=1.
  - Hold until mem_ready=1, then go to NEXT_IDX.
- NEXT_IDX: sum_reset=1, then:
  - If col_j<C-1: col_j++ and go to PE.
  - Else col_j=0. If row_i<R-1: row_i++ and go to PE.
  - Else go to NEXT_LAYER.
- NEXT_LAYER:
  - row_i=col_j=0.
  - If layer_idx==num_layers-1: go to DONE.
  - Else layer_idx++ and go to LOAD_KERNEL.
- DONE: done=1, busy=1 for one cycle, then IDLE. layer_idx, row_i and col_j are held until the next start.
- Arithmetic: address sums are computed at ADDR_W+IDX_W bits, then truncated mod 2^ADDR_W (wrap-around is legal and silent).
- Latency with mem_ready held high:
  - Per layer: N*K + B + R*C*(PE_CYCLES+2) + 1 cycles.
  - done asserts 1 + sum(per-layer) cycles after the start-sampling edge.
- Simultaneous events: mem_ready low during LOAD or WRITE freezes all counters and outputs. A reset edge overrides everything.

Test Plan:
- Defaults, 1 layer, R=C=2, mem_ready=1, start pulse -> done exactly 154 cycles later. 16 kernel reads: wbase..wbase+15, with load_kernel one-hot in 4-beat groups. 64 buffer reads. Writes at obase+0,1,2,3.
- 2 layers (R=C=2, then R=3, C=1) -> layer_idx 0 then 1. Second-layer writes at obase1+0,1,2. Single done pulse.
- mem_ready toggled 1,0,1,0 during LOAD_KERNEL and held low 3 cycles in WRITE -> address and strobes held while low. Total latency grows by exactly the number of stalled cycles.
- num_layers=0 with start -> done in the following cycle, no mem_rd/mem_wr. start asserted while busy -> no effect.
- obase=250, R=C=3 -> write addresses wrap: 250..255, 0, 1, 2.
- Reset asserted mid-PE on layer 1 -> all outputs 0 immediately, no done pulse. A new start runs from layer 0 with correct timing.
